lab2_proc_mem_arbiter: RTL and testbench
========================================

LAB2_PROC_MEM_ARBITER -- requirements
Module: lab2_proc_mem_arbiter

Interface
REQ-001 SHALL have parameter p_max_outstanding, default 4, maximum un-responded requests per source (range 1..7).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports imem_reqstream_msg/val/rdy  input/input/output  mem_req_4B_t/1/1  instruction request from processor.
REQ-005 SHALL have ports imem_respstream_msg/val/rdy  output/output/input  mem_resp_4B_t/1/1  instruction response to processor.
REQ-006 SHALL have ports dmem_reqstream_msg/val/rdy  input/input/output  mem_req_4B_t/1/1  data request from processor.
REQ-007 SHALL have ports dmem_respstream_msg/val/rdy  output/output/input  mem_resp_4B_t/1/1  data response to processor.
REQ-008 SHALL have ports mem_reqstream_msg/val/rdy  output/output/input  mem_req_4B_t/1/1  merged request to single-port memory.
REQ-009 SHALL have ports mem_respstream_msg/val/rdy  input/input/output  mem_resp_4B_t/1/1  merged response from memory.

Function
REQ-010 SHALL hold accepted requests in a one-entry output buffer; mem_reqstream_val asserts the cycle after acceptance (latency 1).
REQ-011 SHALL accept a source request only when buffer empty or dequeuing this cycle (mem_reqstream_val && mem_reqstream_rdy), and that source's outstanding count < p_max_outstanding.
REQ-012 SHALL grant at most one source per cycle; the ungranted source sees rdy=0.
REQ-013 SHALL forward type_, addr, len, data unchanged and rewrite opaque to {src, orig_opaque[6:0]}; src=0 imem, 1 dmem.
REQ-014 SHALL route each response combinationally by mem_respstream_msg.opaque[7]: 0 to imem, 1 to dmem; returned opaque[7] forced to 0, other fields unchanged.
REQ-015 SHALL drive mem_respstream_rdy equal to the rdy of the routed destination; the other destination's val stays 0.
REQ-016 SHALL keep one 3-bit outstanding counter per source: +1 on request acceptance, -1 on response handshake, unchanged when both occur in the same cycle.
REQ-017 SHALL never let a counter exceed p_max_outstanding nor decrement below 0; a response for a source at count 0 is still routed, counter held at 0.
REQ-018 SHALL require no response ordering across sources; responses within one source are in order.

Reset
REQ-019 SHALL on reset: buffer invalid, mem_reqstream_val=0, both counters 0, last-grant register = dmem; imem/dmem_respstream_val=0 unless mem_respstream_val is high.
REQ-020 SHALL on reset asserted mid-transaction discard the buffered request; no request issued in the reset cycle.

Configuration
REQ-021 SHALL with LAB2_PROC_MEM_ARBITER_RR_EN defined arbitrate round-robin: on conflict grant the source not granted last; last-grant updates only on acceptance.
REQ-022 SHALL without LAB2_PROC_MEM_ARBITER_RR_EN use fixed priority, dmem over imem; last-grant register absent.

Structure
REQ-023 SHALL place source-ID constants (LAB2_PROC_MEM_SRC_IMEM=0, _DMEM=1) and opaque-tag bit index (7) in a shared package; mem_req_4B_t/mem_resp_4B_t come from existing mem-msgs definitions.
REQ-024 SHALL factor the arbitration logic into sub-module lab2_proc_mem_arbiter_grant (inputs req[1:0], last-grant state; output one-hot grant).

Verification
REQ-025 SHALL test: imem read addr 0x200 alone, mem rdy=1 -> mem_req val next cycle, addr 0x200, opaque 0x00; response opaque 0x00 appears on imem_resp same cycle.
REQ-026 SHALL test: imem and dmem valid same cycle, RR_EN defined -> issue order imem, dmem, imem, dmem; RR_EN undefined -> dmem issued first each conflict.
REQ-027 SHALL test: dmem read addr 0x1000 -> mem opaque 0x80; response opaque 0x80 data 0xdeadbeef -> dmem_resp data 0xdeadbeef opaque 0x00, imem_resp val 0.
REQ-028 SHALL test: 4 imem requests, no responses (p_max_outstanding=4) -> imem_reqstream_rdy=0 on 5th; one response returns -> rdy=1 next cycle.
REQ-029 SHALL test: mem_reqstream_rdy=0 for 3 cycles with buffer full -> both source rdy=0, buffered msg stable; rdy=1 -> dequeue and new request accepted same cycle.
REQ-030 SHALL test: reset asserted with buffer full and counters 2/1 -> val=0 and counters 0 immediately, without waiting for clk.

Source files
------------

// File: rtl/lab2_proc_mem_arbiter_pkg.sv
// Constants shared by the processor/memory arbiter and its grant logic:
// source IDs, the opaque bit that carries the source tag, counter width,
// and small helpers for tag rewriting and outstanding-count update.
package lab2_proc_mem_arbiter_pkg;

    localparam logic LAB2_PROC_MEM_SRC_IMEM = 1'b0;
    localparam logic LAB2_PROC_MEM_SRC_DMEM = 1'b1;

    // Bit of the opaque field that identifies the source on the memory side.
    localparam int LAB2_PROC_MEM_OPAQUE_SRC_BIT = 7;

    // Outstanding counters cover the full 1..7 range of p_max_outstanding.
    localparam int LAB2_PROC_MEM_CNT_W = 3;

    // Replace the top opaque bit with the source ID.
    function automatic logic [7:0] tag_opaque(
        input logic       src,
        input logic [6:0] orig_low
    );
        return {src, orig_low};
    endfunction

    // Accept and response in the same cycle cancel out; a response arriving
    // while the count is already 0 leaves it at 0.
    function automatic logic [LAB2_PROC_MEM_CNT_W-1:0] next_outstanding(
        input logic [LAB2_PROC_MEM_CNT_W-1:0] count,
        input logic                           accept,
        input logic                           resp
    );
        if (accept && !resp)
            return count + 1'b1;
        if (resp && !accept && (count != '0))
            return count - 1'b1;
        return count;
    endfunction

endpackage

// File: rtl/mem_msgs_pkg.sv
// Memory message formats shared by the processor, caches and memories.
// Request: type_, opaque tag, byte address, length, write data.
// Response: type_, opaque tag, test bits, length, read data.
package mem_msgs_pkg;

    typedef struct packed {
        logic [2:0]  type_;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4B_t;

    typedef struct packed {
        logic [2:0]  type_;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;

endpackage

// File: rtl/lab2_proc_mem_arbiter_grant.sv
// Two-source grant logic for the processor/memory arbiter.
// Grant bit index equals the source ID (0 imem, 1 dmem); output is one-hot or zero.
// LAB2_PROC_MEM_ARBITER_RR_EN selects round-robin; otherwise dmem has fixed priority
// and last_grant is ignored.
module lab2_proc_mem_arbiter_grant
    import lab2_proc_mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

`ifdef LAB2_PROC_MEM_ARBITER_RR_EN
    // Round-robin: on a conflict favour the source that did not win last time.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        grant = 2'b00;
        if (req == 2'b11) begin
            if (last_grant == LAB2_PROC_MEM_SRC_DMEM)
                grant[LAB2_PROC_MEM_SRC_IMEM] = 1'b1;
            else
                grant[LAB2_PROC_MEM_SRC_DMEM] = 1'b1;
        end else begin
            grant = req;
        end
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    // Fixed priority: dmem wins any conflict.
    always_comb begin
        grant = 2'b00;
        if (req[LAB2_PROC_MEM_SRC_DMEM])
            grant[LAB2_PROC_MEM_SRC_DMEM] = 1'b1;
        else if (req[LAB2_PROC_MEM_SRC_IMEM])
            grant[LAB2_PROC_MEM_SRC_IMEM] = 1'b1;
    end
`endif

endmodule

// File: rtl/lab2_proc_mem_arbiter.sv
// Merges instruction and data memory streams onto one single-port memory.
// Requests pass through a one-entry output buffer (one cycle latency) with the
// source ID written into opaque[7]; responses are steered back combinationally
// by that bit, which is cleared on the way out. Per-source outstanding counters
// stop a source once p_max_outstanding requests are unanswered.
// Build option: LAB2_PROC_MEM_ARBITER_RR_EN enables round-robin arbitration
// (default build uses fixed dmem-over-imem priority).
module lab2_proc_mem_arbiter
    import mem_msgs_pkg::*;
    import lab2_proc_mem_arbiter_pkg::*;
#(
    parameter int p_max_outstanding = 4
)(
    input  logic         clk,
    input  logic         reset,

    input  mem_req_4B_t  imem_reqstream_msg,
    input  logic         imem_reqstream_val,
    output logic         imem_reqstream_rdy,

    output mem_resp_4B_t imem_respstream_msg,
    output logic         imem_respstream_val,
    input  logic         imem_respstream_rdy,

    input  mem_req_4B_t  dmem_reqstream_msg,
    input  logic         dmem_reqstream_val,
    output logic         dmem_reqstream_rdy,

    output mem_resp_4B_t dmem_respstream_msg,
    output logic         dmem_respstream_val,
    input  logic         dmem_respstream_rdy,

    output mem_req_4B_t  mem_reqstream_msg,
    output logic         mem_reqstream_val,
    input  logic         mem_reqstream_rdy,

    input  mem_resp_4B_t mem_respstream_msg,
    input  logic         mem_respstream_val,
    output logic         mem_respstream_rdy
);

    localparam logic [LAB2_PROC_MEM_CNT_W-1:0] MAX_OUT = LAB2_PROC_MEM_CNT_W'(p_max_outstanding);

    logic                           buf_val;
    mem_req_4B_t                    buf_msg;
    logic                           buf_free;
    logic [1:0]                     req;
    logic [1:0]                     grant;
    logic                           last_grant;
    mem_req_4B_t                    tagged_msg;
    logic [LAB2_PROC_MEM_CNT_W-1:0] imem_outstanding;
    logic [LAB2_PROC_MEM_CNT_W-1:0] dmem_outstanding;
    logic                           resp_to_dmem;
    logic                           imem_resp_fire;
    logic                           dmem_resp_fire;

    lab2_proc_mem_arbiter_grant u_grant (
        .req        (req),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // Eligibility, grant fan-out and opaque tagging of the winning request.
    always_comb begin
        buf_free = !buf_val || (buf_val && mem_reqstream_rdy);
        req      = 2'b00;
        req[LAB2_PROC_MEM_SRC_IMEM] = imem_reqstream_val && buf_free && (imem_outstanding < MAX_OUT);
        req[LAB2_PROC_MEM_SRC_DMEM] = dmem_reqstream_val && buf_free && (dmem_outstanding < MAX_OUT);

        imem_reqstream_rdy = grant[LAB2_PROC_MEM_SRC_IMEM];
        dmem_reqstream_rdy = grant[LAB2_PROC_MEM_SRC_DMEM];

        if (grant[LAB2_PROC_MEM_SRC_DMEM]) begin
            tagged_msg        = dmem_reqstream_msg;
            tagged_msg.opaque = tag_opaque(LAB2_PROC_MEM_SRC_DMEM, dmem_reqstream_msg.opaque[6:0]);
        end else begin
            tagged_msg        = imem_reqstream_msg;
            tagged_msg.opaque = tag_opaque(LAB2_PROC_MEM_SRC_IMEM, imem_reqstream_msg.opaque[6:0]);
        end
    end

    // Output buffer valid bit: filled on grant, emptied when memory takes it.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset)
            buf_val <= 1'b0;
        else if (|grant)
            buf_val <= 1'b1;
        else if (mem_reqstream_rdy)
            buf_val <= 1'b0;
    end

    // Output buffer payload: captured on grant only.
    always_ff @(posedge clk) begin
        // NOTE: payload is qualified by buf_val, so it needs no reset.
        if (|grant)
            buf_msg <= tagged_msg;
    end

    assign mem_reqstream_val = buf_val;
    assign mem_reqstream_msg = buf_msg;

`ifdef LAB2_PROC_MEM_ARBITER_RR_EN
    // Remember which source won the most recent accepted request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            last_grant <= LAB2_PROC_MEM_SRC_DMEM;
        else if (|grant)
            last_grant <= grant[LAB2_PROC_MEM_SRC_DMEM];
    end
`else
    assign last_grant = LAB2_PROC_MEM_SRC_DMEM;
`endif

    // Steer the memory response to its source by the tag bit and clear the tag.
    always_comb begin
        resp_to_dmem = mem_respstream_msg.opaque[LAB2_PROC_MEM_OPAQUE_SRC_BIT];

        imem_respstream_msg = mem_respstream_msg;
        imem_respstream_msg.opaque[LAB2_PROC_MEM_OPAQUE_SRC_BIT] = 1'b0;
        dmem_respstream_msg = imem_respstream_msg;

        imem_respstream_val = mem_respstream_val && !resp_to_dmem;
        dmem_respstream_val = mem_respstream_val &&  resp_to_dmem;
        mem_respstream_rdy  = resp_to_dmem ? dmem_respstream_rdy : imem_respstream_rdy;

        imem_resp_fire = imem_respstream_val && imem_respstream_rdy;
        dmem_resp_fire = dmem_respstream_val && dmem_respstream_rdy;
    end

    // Per-source outstanding request counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            imem_outstanding <= '0;
            dmem_outstanding <= '0;
        end else begin
            imem_outstanding <= next_outstanding(imem_outstanding,
                                                 grant[LAB2_PROC_MEM_SRC_IMEM], imem_resp_fire);
            dmem_outstanding <= next_outstanding(dmem_outstanding,
                                                 grant[LAB2_PROC_MEM_SRC_DMEM], dmem_resp_fire);
        end
    end

endmodule

// File: tb/tb_lab2_proc_mem_arbiter.sv
// Directed bench for lab2_proc_mem_arbiter (p_max_outstanding = 4).
// Expected arbitration order follows LAB2_PROC_MEM_ARBITER_RR_EN when defined.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_lab2_proc_mem_arbiter;
    import mem_msgs_pkg::*;

    logic         clk;
    logic         reset;
    mem_req_4B_t  imem_reqstream_msg;
    logic         imem_reqstream_val;
    logic         imem_reqstream_rdy;
    mem_resp_4B_t imem_respstream_msg;
    logic         imem_respstream_val;
    logic         imem_respstream_rdy;
    mem_req_4B_t  dmem_reqstream_msg;
    logic         dmem_reqstream_val;
    logic         dmem_reqstream_rdy;
    mem_resp_4B_t dmem_respstream_msg;
    logic         dmem_respstream_val;
    logic         dmem_respstream_rdy;
    mem_req_4B_t  mem_reqstream_msg;
    logic         mem_reqstream_val;
    logic         mem_reqstream_rdy;
    mem_resp_4B_t mem_respstream_msg;
    logic         mem_respstream_val;
    logic         mem_respstream_rdy;

    int errors = 0;
    int checks = 0;

    lab2_proc_mem_arbiter #(.p_max_outstanding(4)) dut (
        .clk                 (clk),
        .reset               (reset),
        .imem_reqstream_msg  (imem_reqstream_msg),
        .imem_reqstream_val  (imem_reqstream_val),
        .imem_reqstream_rdy  (imem_reqstream_rdy),
        .imem_respstream_msg (imem_respstream_msg),
        .imem_respstream_val (imem_respstream_val),
        .imem_respstream_rdy (imem_respstream_rdy),
        .dmem_reqstream_msg  (dmem_reqstream_msg),
        .dmem_reqstream_val  (dmem_reqstream_val),
        .dmem_reqstream_rdy  (dmem_reqstream_rdy),
        .dmem_respstream_msg (dmem_respstream_msg),
        .dmem_respstream_val (dmem_respstream_val),
        .dmem_respstream_rdy (dmem_respstream_rdy),
        .mem_reqstream_msg   (mem_reqstream_msg),
        .mem_reqstream_val   (mem_reqstream_val),
        .mem_reqstream_rdy   (mem_reqstream_rdy),
        .mem_respstream_msg  (mem_respstream_msg),
        .mem_respstream_val  (mem_respstream_val),
        .mem_respstream_rdy  (mem_respstream_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    function automatic mem_req_4B_t make_req(input logic [7:0] opaque, input logic [31:0] addr,
                                             input logic [31:0] data);
        mem_req_4B_t m;
        m.type_  = 3'd0;
        m.opaque = opaque;
        m.addr   = addr;
        m.len    = 2'd0;
        m.data   = data;
        return m;
    endfunction

    function automatic mem_resp_4B_t make_resp(input logic [7:0] opaque, input logic [31:0] data);
        mem_resp_4B_t m;
        m.type_  = 3'd0;
        m.opaque = opaque;
        m.test   = 2'd0;
        m.len    = 2'd0;
        m.data   = data;
        return m;
    endfunction

    task automatic idle_inputs();
        imem_reqstream_val  = 1'b0;
        dmem_reqstream_val  = 1'b0;
        mem_respstream_val  = 1'b0;
        imem_reqstream_msg  = make_req(8'h00, 32'h0, 32'h0);
        dmem_reqstream_msg  = make_req(8'h00, 32'h0, 32'h0);
        mem_respstream_msg  = make_resp(8'h00, 32'h0);
        mem_reqstream_rdy   = 1'b1;
        imem_respstream_rdy = 1'b1;
        dmem_respstream_rdy = 1'b1;
    endtask

    // Returns 4 imem and 4 dmem responses; counters must settle at 0 and hold there.
    task automatic drain_responses();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            mem_respstream_msg = make_resp((i < 4) ? 8'h00 : 8'h80, 32'h0);
            mem_respstream_val = 1'b1;
            #1;
            checks++;
            if (imem_respstream_val !== (i < 4) || dmem_respstream_val !== (i >= 4)) begin
                errors++;
                $display("FAIL drain_route[%0d]: imem_val=%b dmem_val=%b expected imem_val=%b",
                         i, imem_respstream_val, dmem_respstream_val, (i < 4));
            end
        end
        @(negedge clk);
        mem_respstream_val = 1'b0;
        checks++;
        if (dut.imem_outstanding !== 3'd0 || dut.dmem_outstanding !== 3'd0) begin
            errors++;
            $display("FAIL drain_counts: imem=%0d dmem=%0d expected 0/0",
                     dut.imem_outstanding, dut.dmem_outstanding);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (mem_reqstream_val !== 1'b0) begin
            errors++; $display("FAIL reset_mem_val: got %b expected 0", mem_reqstream_val);
        end
        checks++;
        if (imem_respstream_val !== 1'b0 || dmem_respstream_val !== 1'b0) begin
            errors++; $display("FAIL reset_resp_val: imem=%b dmem=%b expected 0/0",
                               imem_respstream_val, dmem_respstream_val);
        end
        checks++;
        if (dut.imem_outstanding !== 3'd0 || dut.dmem_outstanding !== 3'd0) begin
            errors++; $display("FAIL reset_counts: imem=%0d dmem=%0d expected 0/0",
                               dut.imem_outstanding, dut.dmem_outstanding);
        end
        // Response routing stays live during reset.
        mem_respstream_msg = make_resp(8'h80, 32'h5);
        mem_respstream_val = 1'b1;
        #1;
        checks++;
        if (dmem_respstream_val !== 1'b1 || imem_respstream_val !== 1'b0) begin
            errors++; $display("FAIL reset_resp_route: dmem=%b imem=%b expected 1/0",
                               dmem_respstream_val, imem_respstream_val);
        end
        @(negedge clk);
        mem_respstream_val = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_imem_read();
        @(negedge clk);
        imem_reqstream_msg = make_req(8'h00, 32'h200, 32'h0);
        imem_reqstream_val = 1'b1;
        #1;
        checks++;
        if (imem_reqstream_rdy !== 1'b1) begin
            errors++; $display("FAIL imem_accept: rdy=%b expected 1", imem_reqstream_rdy);
        end
        @(negedge clk);
        imem_reqstream_val = 1'b0;
        #1;
        checks++;
        if (mem_reqstream_val !== 1'b1 || mem_reqstream_msg.addr !== 32'h200 ||
            mem_reqstream_msg.opaque !== 8'h00) begin
            errors++; $display("FAIL imem_issue: val=%b addr=%h opaque=%h expected 1/00000200/00",
                               mem_reqstream_val, mem_reqstream_msg.addr, mem_reqstream_msg.opaque);
        end
        @(negedge clk);
        checks++;
        if (mem_reqstream_val !== 1'b0) begin
            errors++; $display("FAIL imem_dequeue: val=%b expected 0", mem_reqstream_val);
        end
        mem_respstream_msg  = make_resp(8'h00, 32'h1234abcd);
        mem_respstream_val  = 1'b1;
        dmem_respstream_rdy = 1'b0;
        #1;
        checks++;
        if (imem_respstream_val !== 1'b1 || imem_respstream_msg.opaque !== 8'h00 ||
            imem_respstream_msg.data !== 32'h1234abcd || dmem_respstream_val !== 1'b0 ||
            mem_respstream_rdy !== 1'b1) begin
            errors++; $display("FAIL imem_resp: ival=%b op=%h data=%h dval=%b mrdy=%b expected 1/00/1234abcd/0/1",
                               imem_respstream_val, imem_respstream_msg.opaque, imem_respstream_msg.data,
                               dmem_respstream_val, mem_respstream_rdy);
        end
        @(negedge clk);
        mem_respstream_val  = 1'b0;
        dmem_respstream_rdy = 1'b1;
    endtask

    task automatic test_dmem_read();
        @(negedge clk);
        dmem_reqstream_msg = make_req(8'h00, 32'h1000, 32'h0);
        dmem_reqstream_val = 1'b1;
        @(negedge clk);
        dmem_reqstream_val = 1'b0;
        #1;
        checks++;
        if (mem_reqstream_val !== 1'b1 || mem_reqstream_msg.addr !== 32'h1000 ||
            mem_reqstream_msg.opaque !== 8'h80) begin
            errors++; $display("FAIL dmem_issue: val=%b addr=%h opaque=%h expected 1/00001000/80",
                               mem_reqstream_val, mem_reqstream_msg.addr, mem_reqstream_msg.opaque);
        end
        @(negedge clk);
        mem_respstream_msg  = make_resp(8'h80, 32'hdeadbeef);
        mem_respstream_val  = 1'b1;
        imem_respstream_rdy = 1'b0;
        #1;
        checks++;
        if (dmem_respstream_val !== 1'b1 || dmem_respstream_msg.data !== 32'hdeadbeef ||
            dmem_respstream_msg.opaque !== 8'h00 || imem_respstream_val !== 1'b0 ||
            mem_respstream_rdy !== 1'b1) begin
            errors++; $display("FAIL dmem_resp: dval=%b data=%h op=%h ival=%b mrdy=%b expected 1/deadbeef/00/0/1",
                               dmem_respstream_val, dmem_respstream_msg.data, dmem_respstream_msg.opaque,
                               imem_respstream_val, mem_respstream_rdy);
        end
        @(negedge clk);
        mem_respstream_val  = 1'b0;
        imem_respstream_rdy = 1'b1;
    endtask

    task automatic test_conflict_order();
        logic [3:0] exp_seq;  // bit i = source of i-th issue (1 = dmem)
`ifdef LAB2_PROC_MEM_ARBITER_RR_EN
        exp_seq = 4'b1010;
`else
        exp_seq = 4'b1111;
`endif
        @(negedge clk);
        imem_reqstream_msg = make_req(8'h11, 32'h100, 32'h0);
        dmem_reqstream_msg = make_req(8'h22, 32'h2000, 32'h0);
        imem_reqstream_val = 1'b1;
        dmem_reqstream_val = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (mem_reqstream_val !== 1'b1 ||
                mem_reqstream_msg.opaque !== (exp_seq[i] ? 8'hA2 : 8'h11)) begin
                errors++; $display("FAIL conflict_order[%0d]: val=%b opaque=%h expected 1/%h",
                                   i, mem_reqstream_val, mem_reqstream_msg.opaque,
                                   exp_seq[i] ? 8'hA2 : 8'h11);
            end
        end
        imem_reqstream_val = 1'b0;
        dmem_reqstream_val = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_outstanding_limit();
        @(negedge clk);
        imem_reqstream_msg = make_req(8'h01, 32'h300, 32'h0);
        imem_reqstream_val = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            checks++;
            if (imem_reqstream_rdy !== (i < 4)) begin
                errors++; $display("FAIL outstanding_rdy[%0d]: rdy=%b expected %b",
                                   i, imem_reqstream_rdy, (i < 4));
            end
        end
        checks++;
        if (dut.imem_outstanding !== 3'd4) begin
            errors++; $display("FAIL outstanding_count: got %0d expected 4", dut.imem_outstanding);
        end
        mem_respstream_msg = make_resp(8'h01, 32'h0);
        mem_respstream_val = 1'b1;
        @(negedge clk);
        mem_respstream_val = 1'b0;
        #1;
        checks++;
        if (imem_reqstream_rdy !== 1'b1) begin
            errors++; $display("FAIL outstanding_release: rdy=%b expected 1", imem_reqstream_rdy);
        end
        imem_reqstream_val = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_pressure();
        logic        exp_imem;
        logic [31:0] exp_addr;
        logic [7:0]  exp_opaque;
`ifdef LAB2_PROC_MEM_ARBITER_RR_EN
        exp_imem = 1'b1; exp_addr = 32'h4000; exp_opaque = 8'h07;
`else
        exp_imem = 1'b0; exp_addr = 32'h5000; exp_opaque = 8'h86;
`endif
        @(negedge clk);
        mem_reqstream_rdy  = 1'b0;
        dmem_reqstream_msg = make_req(8'h05, 32'h3000, 32'h0);
        dmem_reqstream_val = 1'b1;
        @(negedge clk);
        dmem_reqstream_msg = make_req(8'h06, 32'h5000, 32'h0);
        imem_reqstream_msg = make_req(8'h07, 32'h4000, 32'h0);
        imem_reqstream_val = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            checks++;
            if (imem_reqstream_rdy !== 1'b0 || dmem_reqstream_rdy !== 1'b0 ||
                mem_reqstream_val !== 1'b1 || mem_reqstream_msg.addr !== 32'h3000 ||
                mem_reqstream_msg.opaque !== 8'h85) begin
                errors++; $display("FAIL stall[%0d]: irdy=%b drdy=%b val=%b addr=%h op=%h expected 0/0/1/00003000/85",
                                   i, imem_reqstream_rdy, dmem_reqstream_rdy, mem_reqstream_val,
                                   mem_reqstream_msg.addr, mem_reqstream_msg.opaque);
            end
        end
        @(negedge clk);
        mem_reqstream_rdy = 1'b1;
        #1;
        checks++;
        if (imem_reqstream_rdy !== exp_imem || dmem_reqstream_rdy !== !exp_imem) begin
            errors++; $display("FAIL stall_release: irdy=%b drdy=%b expected %b/%b",
                               imem_reqstream_rdy, dmem_reqstream_rdy, exp_imem, !exp_imem);
        end
        @(negedge clk);
        #1;
        checks++;
        if (mem_reqstream_val !== 1'b1 || mem_reqstream_msg.addr !== exp_addr ||
            mem_reqstream_msg.opaque !== exp_opaque) begin
            errors++; $display("FAIL stall_next: val=%b addr=%h op=%h expected 1/%h/%h",
                               mem_reqstream_val, mem_reqstream_msg.addr, mem_reqstream_msg.opaque,
                               exp_addr, exp_opaque);
        end
        imem_reqstream_val = 1'b0;
        dmem_reqstream_val = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        imem_reqstream_msg = make_req(8'h03, 32'h600, 32'h0);
        imem_reqstream_val = 1'b1;
        @(negedge clk);
        @(negedge clk);
        imem_reqstream_val = 1'b0;
        dmem_reqstream_msg = make_req(8'h04, 32'h7000, 32'h0);
        dmem_reqstream_val = 1'b1;
        @(negedge clk);
        dmem_reqstream_val = 1'b0;
        mem_reqstream_rdy  = 1'b0;
        #1;
        checks++;
        if (mem_reqstream_val !== 1'b1 || dut.imem_outstanding !== 3'd2 ||
            dut.dmem_outstanding !== 3'd1) begin
            errors++; $display("FAIL midreset_setup: val=%b imem=%0d dmem=%0d expected 1/2/1",
                               mem_reqstream_val, dut.imem_outstanding, dut.dmem_outstanding);
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (mem_reqstream_val !== 1'b0 || dut.imem_outstanding !== 3'd0 ||
            dut.dmem_outstanding !== 3'd0) begin
            errors++; $display("FAIL midreset_async: val=%b imem=%0d dmem=%0d expected 0/0/0",
                               mem_reqstream_val, dut.imem_outstanding, dut.dmem_outstanding);
        end
        @(negedge clk);
        reset = 1'b0;
        mem_reqstream_rdy = 1'b1;
        #1;
        checks++;
        if (mem_reqstream_val !== 1'b0) begin
            errors++; $display("FAIL midreset_no_issue: val=%b expected 0", mem_reqstream_val);
        end
    endtask

    initial begin
        test_reset();
        test_imem_read();
        test_dmem_read();
        test_conflict_order();
        drain_responses();
        test_outstanding_limit();
        drain_responses();
        test_back_pressure();
        drain_responses();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
